// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier: unpack/classify, mantissa multiply,
// normalise/round/pack. Subnormals flush to zero; round-to-nearest-even; IEEE-style flags.
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] dataA,
    input  logic [W-1:0] dataB,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] dataR,
    output logic [3:0]   flags
);
    localparam int STAGES = 3;
    localparam int EW = EXP_W + 2;
    localparam int MW = MAN_W + 1;
    localparam int PW = 2 * MW;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EXP_MAX = {2'b00, EXP_ONES};

    typedef struct packed {
        logic                 sign;
        logic                 nan;
        logic                 nv;
        logic                 inf;
        logic                 zero;
        logic signed [EW-1:0] exp;
        logic [MW-1:0]        ma;
        logic [MW-1:0]        mb;
    } s1_t;

    typedef struct packed {
        logic                 sign;
        logic                 nan;
        logic                 nv;
        logic                 inf;
        logic                 zero;
        logic signed [EW-1:0] exp;
        logic [PW-1:0]        prod;
    } s2_t;

    logic [STAGES:1] vld_pipe;
    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;

    // Whole pipe moves as one; a held output freezes every stage behind it.
    assign in_ready  = ~out_valid | out_ready;
    assign out_valid = vld_pipe[STAGES];

    // ---- S1: unpack and classify
    logic                 sa, sb;
    logic [EXP_W-1:0]     ea, eb;
    logic [MAN_W-1:0]     fa, fb;
    logic                 a_zero, a_inf, a_nan, a_snan;
    logic                 b_zero, b_inf, b_nan, b_snan;
    logic                 zero_inf;

    assign {sa, ea, fa} = dataA;
    assign {sb, eb, fb} = dataB;

    assign a_zero = (ea == '0);
    assign a_inf  = (ea == EXP_ONES) && (fa == '0);
    assign a_nan  = (ea == EXP_ONES) && (fa != '0);
    assign a_snan = a_nan && !fa[MAN_W-1];
    assign b_zero = (eb == '0);
    assign b_inf  = (eb == EXP_ONES) && (fb == '0);
    assign b_nan  = (eb == EXP_ONES) && (fb != '0);
    assign b_snan = b_nan && !fb[MAN_W-1];
    assign zero_inf = (a_zero & b_inf) | (a_inf & b_zero);

    always_comb begin
        s1_d      = '0;
        s1_d.sign = sa ^ sb;
        s1_d.nan  = a_nan | b_nan | zero_inf;
        s1_d.nv   = a_snan | b_snan | zero_inf;
        s1_d.inf  = a_inf | b_inf;
        s1_d.zero = a_zero | b_zero;
        s1_d.exp  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
        s1_d.ma   = {1'b1, fa};
        s1_d.mb   = {1'b1, fb};
    end

    // ---- S2: mantissa multiply
    always_comb begin
        s2_d      = '0;
        s2_d.sign = s1_q.sign;
        s2_d.nan  = s1_q.nan;
        s2_d.nv   = s1_q.nv;
        s2_d.inf  = s1_q.inf;
        s2_d.zero = s1_q.zero;
        s2_d.exp  = s1_q.exp;
        s2_d.prod = PW'(s1_q.ma) * PW'(s1_q.mb);
    end

    // ---- S3: normalise, round, resolve specials, pack
    logic                 norm_hi, g, r, st, inc, carry, nx, of, uf;
    logic [MAN_W-1:0]     frac_t, frac_r;
    logic [1:0]           exp_adj;
    logic signed [EW-1:0] exp_f;
    logic [W-1:0]         res;
    logic [3:0]           res_flags;

    always_comb begin
        norm_hi = s2_q.prod[PW-1];
        if (norm_hi) begin
            frac_t = s2_q.prod[PW-2 -: MAN_W];
            g      = s2_q.prod[MAN_W];
            r      = s2_q.prod[MAN_W-1];
            st     = |s2_q.prod[MAN_W-2:0];
        end else begin
            frac_t = s2_q.prod[PW-3 -: MAN_W];
            g      = s2_q.prod[MAN_W-1];
            r      = s2_q.prod[MAN_W-2];
            st     = |s2_q.prod[MAN_W-3:0];
        end
        inc     = g & (r | st | frac_t[0]);
        // All-ones fraction plus increment wraps to zero and bumps the exponent.
        carry   = inc & (&frac_t);
        frac_r  = frac_t + MAN_W'(inc);
        exp_adj = {1'b0, norm_hi} + {1'b0, carry};
        exp_f   = s2_q.exp + $signed({{(EW-2){1'b0}}, exp_adj});
        nx      = g | r | st;
        of      = !exp_f[EW-1] && (exp_f >= EXP_MAX);
        uf      = exp_f[EW-1] || (exp_f == '0);

        res       = '0;
        res_flags = '0;
        if (s2_q.nan) begin
            res       = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
            res_flags = {s2_q.nv, 3'b000};
        end else if (s2_q.inf) begin
            res = {s2_q.sign, EXP_ONES, {MAN_W{1'b0}}};
        end else if (s2_q.zero) begin
            res = {s2_q.sign, {(W-1){1'b0}}};
        end else if (of) begin
            res       = {s2_q.sign, EXP_ONES, {MAN_W{1'b0}}};
            res_flags = 4'b0101;
        end else if (uf) begin
            res       = {s2_q.sign, {(W-1){1'b0}}};
            res_flags = 4'b0011;
        end else begin
            res       = {s2_q.sign, exp_f[EXP_W-1:0], frac_r};
            res_flags = {3'b000, nx};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
            dataR    <= '0;
            flags    <= '0;
        end else if (in_ready) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            dataR    <= res;
            flags    <= res_flags;
        end
    end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe: single and double precision instances, checked
// against an arithmetic reference that rounds via quotient/remainder of the exact product.
module tb_fp_mul_pipe;
    logic        clk, rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] dataA, dataB, dataR;
    logic [3:0]  flags;
    logic        in_valid64, in_ready64, out_valid64, out_ready64;
    logic [63:0] dataA64, dataB64, dataR64;
    logic [3:0]  flags64;

    int n_tests, n_fail;
    logic rand_bp, force_ready;

    typedef struct packed { logic [63:0] r; logic [3:0] f; } exp_t;
    exp_t q32[$];
    exp_t q64[$];

    fp_mul_pipe u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .dataA(dataA), .dataB(dataB), .out_valid(out_valid), .out_ready(out_ready),
        .dataR(dataR), .flags(flags)
    );

    fp_mul_pipe #(.EXP_W(11), .MAN_W(52)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid64), .in_ready(in_ready64),
        .dataA(dataA64), .dataB(dataB64), .out_valid(out_valid64), .out_ready(out_ready64),
        .dataR(dataR64), .flags(flags64)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Exact product, then round to mw fraction bits by quotient/remainder against one half.
    function automatic void ref_mul(input int ew, input int mw, input logic [63:0] a,
                                    input logic [63:0] b, output logic [63:0] r,
                                    output logic [3:0] f);
        logic [63:0]  emax, fmask, ea, eb, fa, fb, sbit;
        logic [127:0] p, q, rem, half;
        logic         za, zb, ia, ib, na, nb, sna, snb, s;
        int           e, k, sh, bias;
        bias  = (1 << (ew - 1)) - 1;
        emax  = (64'd1 << ew) - 1;
        fmask = (64'd1 << mw) - 1;
        ea = (a >> mw) & emax;  fa = a & fmask;
        eb = (b >> mw) & emax;  fb = b & fmask;
        s    = a[ew+mw] ^ b[ew+mw];
        sbit = s ? (64'd1 << (ew + mw)) : 64'd0;
        za = (ea == 0);  ia = (ea == emax) && (fa == 0);  na = (ea == emax) && (fa != 0);
        zb = (eb == 0);  ib = (eb == emax) && (fb == 0);  nb = (eb == emax) && (fb != 0);
        sna = na && !fa[mw-1];
        snb = nb && !fb[mw-1];
        f = 4'b0000;
        if (na || nb || (za && ib) || (ia && zb)) begin
            r = (emax << mw) | (64'd1 << (mw - 1));
            f[3] = sna || snb || (za && ib) || (ia && zb);
            return;
        end
        if (ia || ib) begin r = sbit | (emax << mw); return; end
        if (za || zb) begin r = sbit; return; end
        p = ({64'd0, fa} | (128'd1 << mw)) * ({64'd0, fb} | (128'd1 << mw));
        k = 0;
        for (int i = 0; i < 128; i++) if (p[i]) k = i;
        e    = int'(ea) + int'(eb) - bias + (k - 2 * mw);
        sh   = k - mw;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 128'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        if (q == (128'd1 << (mw + 1))) begin q = q >> 1; e = e + 1; end
        if (e >= int'(emax)) begin
            r = sbit | (emax << mw); f = 4'b0101;
        end else if (e <= 0) begin
            r = sbit; f = 4'b0011;
        end else begin
            r = sbit | (64'(e) << mw) | (q[63:0] & fmask);
            f = {3'b000, rem != 0};
        end
    endfunction

    function automatic logic [31:0] rnd_norm();
        return {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
    endfunction

    function automatic logic [31:0] rnd32();
        logic s;
        s = 1'($urandom);
        case ($urandom_range(0, 9))
            0: return $urandom;
            5: case ($urandom_range(0, 8))
                   0: return 32'h00000000;
                   1: return 32'h80000000;
                   2: return 32'h7F800000;
                   3: return 32'hFF800000;
                   4: return 32'h7FC00001;
                   5: return 32'h7F800005;
                   6: return 32'h007FFFFF;
                   7: return 32'h7F7FFFFF;
                   default: return 32'h00800000;
               endcase
            6: return {s, 8'($urandom_range(190, 254)), 23'($urandom)};
            7: return {s, 8'($urandom_range(1, 60)), 23'($urandom)};
            8: return {s, 8'($urandom_range(110, 144)), 23'($urandom_range(0, 255)) << 15};
            default: return {s, 8'($urandom_range(100, 154)), 23'($urandom)};
        endcase
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] b, input bit use_c,
                        input logic [31:0] cr, input logic [3:0] cf);
        logic [63:0] mr;
        logic [3:0]  mf;
        bit          acc;
        exp_t        e;
        acc = 0;
        @(negedge clk);
        in_valid = 1; dataA = a; dataB = b;
        for (int t = 0; t < 500 && !acc; t++) begin
            #4 acc = in_ready;
            @(posedge clk);
            if (!acc) @(negedge clk);
        end
        #1 in_valid = 0;
        if (acc) begin
            if (use_c) begin
                e.r = {32'd0, cr}; e.f = cf;
            end else begin
                ref_mul(8, 23, {32'd0, a}, {32'd0, b}, mr, mf);
                e.r = mr; e.f = mf;
            end
            q32.push_back(e);
        end else begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout: in_ready got %b expected 1", in_ready);
        end
    endtask

    task automatic send64(input logic [63:0] a, input logic [63:0] b, input bit use_c,
                          input logic [63:0] cr, input logic [3:0] cf);
        logic [63:0] mr;
        logic [3:0]  mf;
        bit          acc;
        exp_t        e;
        @(negedge clk);
        in_valid64 = 1; dataA64 = a; dataB64 = b;
        #4 acc = in_ready64;
        @(posedge clk);
        #1 in_valid64 = 0;
        if (acc) begin
            if (use_c) begin
                e.r = cr; e.f = cf;
            end else begin
                ref_mul(11, 52, a, b, mr, mf);
                e.r = mr; e.f = mf;
            end
            q64.push_back(e);
        end else begin
            n_tests++; n_fail++;
            $display("FAIL send64_not_ready: in_ready got 0 expected 1");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && (q32.size() != 0 || q64.size() != 0); i++) @(negedge clk);
        check("drain_pending", 64'(q32.size() + q64.size()), 64'd0);
    endtask

    initial begin
        out_ready = 1;
        forever begin
            @(negedge clk);
            #1 out_ready = rand_bp ? ($urandom_range(0, 2) != 0) : force_ready;
        end
    end

    // Monitor: samples just before each rising edge, where the transfer is decided.
    initial begin
        logic        hold;
        logic [31:0] held_r;
        logic [3:0]  held_f;
        exp_t        e;
        hold = 0; held_r = 0; held_f = 0;
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                hold = 0;
                continue;
            end
            if (hold) check("hold_stable", {28'd0, flags, dataR}, {28'd0, held_f, held_r});
            if (out_valid && out_ready) begin
                if (q32.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_out32: got %h expected no result", dataR);
                end else begin
                    e = q32.pop_front();
                    check("dataR32", {32'd0, dataR}, e.r);
                    check("flags32", {60'd0, flags}, {60'd0, e.f});
                end
            end
            hold = out_valid && !out_ready;
            held_r = dataR; held_f = flags;
            if (out_valid64) begin
                if (q64.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_out64: got %h expected no result", dataR64);
                end else begin
                    e = q64.pop_front();
                    check("dataR64", dataR64, e.r);
                    check("flags64", {60'd0, flags64}, {60'd0, e.f});
                end
            end
        end
    end

    initial begin
        logic [31:0] xa, xb, ya, yb;
        n_tests = 0; n_fail = 0;
        rst_n = 0; in_valid = 0; dataA = 0; dataB = 0;
        in_valid64 = 0; dataA64 = 0; dataB64 = 0; out_ready64 = 1;
        force_ready = 1; rand_bp = 0;
        repeat (2) @(negedge clk);
        #2;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_dataR", {32'd0, dataR}, 64'd0);
        check("rst_flags", {60'd0, flags}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk) rst_n = 1;

        send(32'h41480000, 32'hC0A66666, 1, 32'hC2820000, 4'b0001);
        send(32'h3F800000, 32'h3F800000, 1, 32'h3F800000, 4'b0000);
        send(32'h7F7FFFFF, 32'h40000000, 1, 32'h7F800000, 4'b0101);
        send(32'h00000000, 32'hFF800000, 1, 32'h7FC00000, 4'b1000);
        send(32'h7F800001, 32'h3F800000, 1, 32'h7FC00000, 4'b1000);
        send(32'h80000000, 32'h40400000, 1, 32'h80000000, 4'b0000);
        send(32'h00800000, 32'h3F000000, 1, 32'h00000000, 4'b0011);
        send(32'h007FFFFF, 32'h3F800000, 1, 32'h00000000, 4'b0000);
        send(32'h7FC00000, 32'h00000000, 1, 32'h7FC00000, 4'b0000);
        send(32'h7F800000, 32'hC0000000, 1, 32'hFF800000, 4'b0000);
        drain();

        // Backpressure: three fill the pipe, the fourth must be refused.
        force_ready = 0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) send(rnd_norm(), rnd_norm(), 0, 0, 0);
        xa = rnd_norm(); xb = rnd_norm(); ya = rnd_norm(); yb = rnd_norm();
        @(negedge clk);
        in_valid = 1; dataA = xa; dataB = xb;
        for (int i = 0; i < 4; i++) begin
            #4 check("in_ready_stall", {63'd0, in_ready}, 64'd0);
            @(negedge clk);
        end
        in_valid = 0;
        force_ready = 1;
        send(xa, xb, 0, 0, 0);
        send(ya, yb, 0, 0, 0);
        drain();

        send64(64'h4029000000000000, 64'hC014CCCCCCCCCCCD, 1, 64'hC050400000000000, 4'b0001);
        send64(64'h3FF0000000000000, 64'h3FF0000000000000, 1, 64'h3FF0000000000000, 4'b0000);
        send64(64'h7FEFFFFFFFFFFFFF, 64'h4000000000000000, 1, 64'h7FF0000000000000, 4'b0101);
        for (int i = 0; i < 20; i++)
            send64({1'($urandom), 11'($urandom_range(900, 1150)), 52'({$urandom, $urandom})},
                   {1'($urandom), 11'($urandom_range(900, 1150)), 52'({$urandom, $urandom})},
                   0, 0, 0);
        drain();

        rand_bp = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) @(negedge clk);
            else send(rnd32(), rnd32(), 0, 0, 0);
        end
        rand_bp = 0;
        drain();

        // Asynchronous reset with three operations in flight.
        for (int i = 0; i < 3; i++) send(rnd_norm(), rnd_norm(), 0, 0, 0);
        #1 check("inflight_out_valid", {63'd0, out_valid}, 64'd1);
        rst_n = 0;
        #1;
        check("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("async_rst_dataR", {32'd0, dataR}, 64'd0);
        check("async_rst_flags", {60'd0, flags}, 64'd0);
        q32.delete();
        q64.delete();
        repeat (2) @(negedge clk);
        rst_n = 1;
        #1 check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (10) @(negedge clk);
        send(32'h41480000, 32'hC0A66666, 1, 32'hC2820000, 4'b0001);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
